// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a field bundle into a 32-bit word and hands it
// to an instruction-memory writer with a byte address and a running word count.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [31:0]       imm_in,
    output logic [31:0]       instruccion,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              err_opcode,
    output logic              err_rango,
    output logic [15:0]       n_instr
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_d;

    logic        accept, handoff;
    logic [31:0] enc_word;
    logic        enc_eop, enc_erng;
    logic        i_ok, b_ok, j_ok;

    always_comb begin
        state_d   = state;
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
        accept    = 1'b0;
        handoff   = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (out_ready) begin
                handoff = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Range checks: sign-extension bits above the encodable field must all match.
    always_comb begin
        i_ok     = (&imm_in[31:11]) | ~(|imm_in[31:11]);
        b_ok     = ((&imm_in[31:12]) | ~(|imm_in[31:12])) & ~imm_in[0];
        j_ok     = ((&imm_in[31:20]) | ~(|imm_in[31:20])) & ~imm_in[0];
        enc_word = '0;
        enc_eop  = 1'b0;
        enc_erng = 1'b0;
        case (opcode)
            OPC_IMM, OPC_LOAD: begin
                enc_word = {imm_in[11:0], rs1, funct3, rd, opcode};
                enc_erng = ~i_ok;
            end
            OPC_JALR: begin
                enc_word = {imm_in[11:0], rs1, 3'b000, rd, opcode};
                enc_erng = ~i_ok;
            end
            OPC_LUI, OPC_AUIPC: begin
                enc_word = {imm_in[31:12], rd, opcode};
                enc_erng = |imm_in[11:0];
            end
            OPC_OP: begin
                enc_word = {imm_in[6:0], rs2, rs1, funct3, rd, opcode};
                enc_erng = |imm_in[31:7];
            end
            OPC_STORE: begin
                enc_word = {imm_in[11:5], rs2, rs1, funct3, imm_in[4:0], opcode};
                enc_erng = ~i_ok;
            end
            OPC_BRANCH: begin
                enc_word = {imm_in[12], imm_in[10:5], rs2, rs1, funct3,
                            imm_in[4:1], imm_in[11], opcode};
                enc_erng = ~b_ok;
            end
            OPC_JAL: begin
                enc_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12],
                            rd, opcode};
                enc_erng = ~j_ok;
            end
            default: begin
                enc_word = 32'h0000_0013;
                enc_eop  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruccion <= '0;
            err_opcode  <= 1'b0;
            err_rango   <= 1'b0;
            mem_addr    <= BASE;
            n_instr     <= '0;
        end else if (clear) begin
            mem_addr <= BASE;
            n_instr  <= '0;
        end else begin
            if (accept) begin
                instruccion <= enc_word;
                err_opcode  <= enc_eop;
                err_rango   <= enc_erng;
            end
            if (handoff) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                n_instr  <= n_instr + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words are queued when a bundle is
// accepted and compared when the encoder presents its output.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] imm_in;
    logic [31:0] instruccion;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  mem_addr;
    logic        err_opcode;
    logic        err_rango;
    logic [15:0] n_instr;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
        .imm_in(imm_in), .instruccion(instruccion), .out_valid(out_valid),
        .out_ready(out_ready), .mem_addr(mem_addr), .err_opcode(err_opcode),
        .err_rango(err_rango), .n_instr(n_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        eop;
        logic        erng;
        logic [7:0]  addr;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_n    = 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic [2:0] f3, input logic [31:0] imm);
        opcode = op; rs1 = r1; rs2 = r2; rd = d; funct3 = f3; imm_in = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] w, input logic eo, input logic er);
        exp_t e;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        set_in(op, r1, r2, d, f3, imm);
        in_valid = 1'b1;
        e.word = w; e.eop = eo; e.erng = er; e.addr = m_addr;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take();
        exp_t e;
        int   n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            e = q.pop_front();
            chk("instruccion", instruccion, e.word);
            chk("err_opcode", {31'd0, err_opcode}, {31'd0, e.eop});
            chk("err_rango", {31'd0, err_rango}, {31'd0, e.erng});
            chk("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        end
        tick();
        out_ready = 1'b0;
        m_addr = m_addr + 8'd4;
        m_n    = m_n + 16'd1;
        chk("n_instr", {16'd0, n_instr}, {16'd0, m_n});
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("mem_addr_next", {24'd0, mem_addr}, {24'd0, m_addr});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_instr"}, instruccion, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_n_instr"}, {16'd0, n_instr}, 32'd0);
        chk({tag, "_err_op"}, {31'd0, err_opcode}, 32'd0);
        chk({tag, "_err_rng"}, {31'd0, err_rango}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk_reset_state("reset");

        // Spec vectors and standard RV32I encodings
        send(7'b0010011, 5'd2, 5'd0, 5'd1, 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 1'b0); take();
        send(7'b1100011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0, 1'b0); take();
        send(7'b0110111, 5'd0, 5'd0, 5'd5, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0); take();
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0003, 32'h0000_0163, 1'b0, 1'b1); take();
        send(7'h7F,      5'd1, 5'd2, 5'd3, 3'd1, 32'h0000_1234, 32'h0000_0013, 1'b1, 1'b0); take();
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0000, 32'h0020_81B3, 1'b0, 1'b0); take();
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0020, 32'h4020_81B3, 1'b0, 1'b0); take();
        send(7'b0100011, 5'd1, 5'd2, 5'd7, 3'd2, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b0); take();
        send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFF8, 32'hFF9F_F06F, 1'b0, 1'b0); take();
        send(7'b1100111, 5'd5, 5'd0, 5'd1, 3'd7, 32'h0000_0000, 32'h0002_80E7, 1'b0, 1'b0); take();
        send(7'b0000011, 5'd6, 5'd0, 5'd5, 3'd2, 32'h0000_0004, 32'h0043_2283, 1'b0, 1'b0); take();
        send(7'b0010111, 5'd0, 5'd0, 5'd1, 3'd0, 32'h0000_1000, 32'h0000_1097, 1'b0, 1'b0); take();
        // Range-error cases: word still built from truncated fields
        send(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h8000_0013, 1'b0, 1'b1); take();
        send(7'b0110111, 5'd0, 5'd0, 5'd5, 3'd0, 32'h1234_5001, 32'h1234_52B7, 1'b0, 1'b1); take();
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0080, 32'h0020_81B3, 1'b0, 1'b1); take();
        send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0001, 32'h0000_006F, 1'b0, 1'b1); take();

        // Back-pressure: outputs frozen while a new bundle waits on the inputs
        send(7'b0010011, 5'd2, 5'd0, 5'd1, 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 1'b0);
        set_in(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0000);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_instr", instruccion, 32'hFFF1_0093);
            chk("stall_addr", {24'd0, mem_addr}, {24'd0, m_addr});
            tick();
        end
        take();
        chk("post_handoff_in_ready", {31'd0, in_ready}, 32'd1);
        q.push_back('{word: 32'h0020_81B3, eop: 1'b0, erng: 1'b0, addr: m_addr});
        tick();
        in_valid = 1'b0;
        take();

        // Clear, then 64 handoffs to wrap the 8-bit address
        clear = 1'b1; tick(); clear = 1'b0;
        m_addr = 8'h00; m_n = 16'h0000;
        chk("clear_addr", {24'd0, mem_addr}, 32'd0);
        chk("clear_n", {16'd0, n_instr}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            send(7'b0010011, 5'd2, 5'd0, 5'd1, 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 1'b0);
            take();
        end
        chk("wrap_addr", {24'd0, mem_addr}, 32'd0);
        chk("wrap_n", {16'd0, n_instr}, 32'd64);

        // Clear in HOLD drops the pending word
        send(7'b0110111, 5'd0, 5'd0, 5'd5, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0);
        void'(q.pop_back());
        clear = 1'b1; out_ready = 1'b1; tick(); clear = 1'b0; out_ready = 1'b0;
        m_addr = 8'h00; m_n = 16'h0000;
        chk("clrhold_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clrhold_addr", {24'd0, mem_addr}, 32'd0);
        chk("clrhold_n", {16'd0, n_instr}, 32'd0);
        chk("clrhold_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in HOLD, asserted together with clear; pending word never handed off
        send(7'b1100011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0, 1'b0);
        void'(q.pop_back());
        rst_n = 1'b0; clear = 1'b1; tick(); rst_n = 1'b1; clear = 1'b0;
        chk_reset_state("rsthold");
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("rsthold_no_handoff", {16'd0, n_instr}, 32'd0);
        chk("rsthold_no_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
